// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu : execute-stage multiply/divide unit
//
// Holds the architectural HI/LO registers and runs mult/multu/div/divu in the
// background. The arithmetic result is computed combinationally when the
// operation is launched and parked in PHI/PLO. A down-counter then models the
// latency, and the parked result is copied into HI/LO on the final busy cycle.
// mfhi/mflo read data is combinational. mthi/mtlo write at the clock edge.
//
// Parameters
//   MULT_CYCLES : busy cycles for mult/multu (default 5)
//   DIV_CYCLES  : busy cycles for div/divu   (default 10, must fit in 4 bits)
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous active-low reset
//   E_RD1    in  32  operand A (rs), also the mthi/mtlo source
//   E_RD2    in  32  operand B (rt)
//   E_MDUOp  in   4  0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                    7 mthi,8 mtlo, 9-15 none
//   E_Start  in   1  launch strobe for ops 1-4
//   E_Busy   out  1  operation in progress
//   E_HI     out 32  HI register
//   E_LO     out 32  LO register
//   E_MDUOut out 32  HI for mfhi, LO for mflo, otherwise 0
// ---------------------------------------------------------------------------
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_Start,
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic [31:0] E_MDUOut
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_LEN = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LEN  = 4'(DIV_CYCLES);

  // Signed 32x32 -> 64 product.
  function automatic logic [63:0] f_mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    p  = sa * sb;
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] f_mul_u(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua;
    logic [63:0] ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Unsigned divide, returns {remainder, quotient}. A zero divisor is
  // replaced by 1 so the datapath never divides by zero; that result is
  // never committed anyway.
  function automatic logic [63:0] f_div_u(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    d = (b == 32'd0) ? 32'd1 : b;
    q = a / d;
    r = a % d;
    return {r, q};
  endfunction

  // Signed divide on magnitudes, returns {remainder, quotient}. Quotient
  // truncates toward zero, remainder takes the dividend's sign. Working on
  // magnitudes makes 0x80000000 / -1 fall out naturally as 0x80000000 rem 0
  // (the magnitude 0x80000000 is representable unsigned and its negation
  // wraps back to itself).
  function automatic logic [63:0] f_div_s(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [63:0] qr;
    logic [31:0] q;
    logic [31:0] r;
    ma = a[31] ? (~a + 32'd1) : a;
    mb = b[31] ? (~b + 32'd1) : b;
    qr = f_div_u(ma, mb);
    q  = qr[31:0];
    r  = qr[63:32];
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  // State
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_phi;
  logic [31:0] r_plo;
  logic [3:0]  r_cnt;
  logic        r_divz;

  // Next-state
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;
  logic [31:0] w_phi_nxt;
  logic [31:0] w_plo_nxt;
  logic [3:0]  w_cnt_nxt;
  logic        w_divz_nxt;

  logic        w_idle;
  logic        w_is_arith;
  logic        w_is_div;
  logic        w_launch;
  logic [63:0] w_res;
  logic [3:0]  w_len;

  assign w_idle     = (r_cnt == 4'd0);
  assign w_is_arith = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU) ||
                      (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
  assign w_is_div   = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
  assign w_launch   = w_idle && E_Start && w_is_arith;
  assign w_len      = w_is_div ? DIV_LEN : MULT_LEN;

  // Result datapath, {hi, lo}
  always_comb begin
    w_res = 64'd0;
    case (E_MDUOp)
      OP_MULT:  w_res = f_mul_s(E_RD1, E_RD2);
      OP_MULTU: w_res = f_mul_u(E_RD1, E_RD2);
      OP_DIV:   w_res = f_div_s(E_RD1, E_RD2);
      OP_DIVU:  w_res = f_div_u(E_RD1, E_RD2);
      default:  w_res = 64'd0;
    endcase
  end

  // Next-state: RUN only counts down and commits; IDLE accepts launches and
  // mthi/mtlo. Anything arriving during RUN is dropped.
  always_comb begin
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    w_phi_nxt  = r_phi;
    w_plo_nxt  = r_plo;
    w_cnt_nxt  = r_cnt;
    w_divz_nxt = r_divz;
    if (!w_idle) begin
      w_cnt_nxt = r_cnt - 4'd1;
      if ((r_cnt == 4'd1) && !r_divz) begin
        w_hi_nxt = r_phi;
        w_lo_nxt = r_plo;
      end
    end else begin
      if (w_launch) begin
        w_phi_nxt  = w_res[63:32];
        w_plo_nxt  = w_res[31:0];
        w_divz_nxt = w_is_div && (E_RD2 == 32'd0);
        w_cnt_nxt  = w_len;
      end
      if (E_MDUOp == OP_MTHI) w_hi_nxt = E_RD1;
      if (E_MDUOp == OP_MTLO) w_lo_nxt = E_RD1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_phi  <= 32'd0;
      r_plo  <= 32'd0;
      r_cnt  <= 4'd0;
      r_divz <= 1'b0;
    end else begin
      r_hi   <= w_hi_nxt;
      r_lo   <= w_lo_nxt;
      r_phi  <= w_phi_nxt;
      r_plo  <= w_plo_nxt;
      r_cnt  <= w_cnt_nxt;
      r_divz <= w_divz_nxt;
    end
  end

  assign E_Busy = !w_idle;
  assign E_HI   = r_hi;
  assign E_LO   = r_lo;

  always_comb begin
    E_MDUOut = 32'd0;
    case (E_MDUOp)
      OP_MFHI: E_MDUOut = r_hi;
      OP_MFLO: E_MDUOut = r_lo;
      default: E_MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: reset abort, signed/unsigned multiply, division
// corner cases, divide by zero and operations dropped while busy.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] E_RD1;
  logic [31:0] E_RD2;
  logic [3:0]  E_MDUOp;
  logic        E_Start;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_MDUOut;

  int total;
  int bad;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_RD1    (E_RD1),
    .E_RD2    (E_RD2),
    .E_MDUOp  (E_MDUOp),
    .E_Start  (E_Start),
    .E_Busy   (E_Busy),
    .E_HI     (E_HI),
    .E_LO     (E_LO),
    .E_MDUOut (E_MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge: inputs driven here hold for
  // the whole cycle and outputs are settled when checked.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch an op in the current cycle and check the busy window of len cycles,
  // ending in the first idle cycle after it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int len);
    E_MDUOp = op; E_RD1 = a; E_RD2 = b; E_Start = 1'b1;
    chk({tag, "_busy_launch_cycle"}, {31'd0, E_Busy}, 32'd0);
    cyc();
    E_MDUOp = 4'd0; E_Start = 1'b0; E_RD1 = 32'd0; E_RD2 = 32'd0;
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_busy%0d", tag, i + 1), {31'd0, E_Busy}, 32'd1);
      cyc();
    end
    chk({tag, "_busy_end"}, {31'd0, E_Busy}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; E_RD1 = 32'd0; E_RD2 = 32'd0; E_MDUOp = 4'd0; E_Start = 1'b0;
    cyc(); cyc();
    chk("rst_busy", {31'd0, E_Busy}, 32'd0);
    chk("rst_hi", E_HI, 32'd0);
    chk("rst_lo", E_LO, 32'd0);
    E_MDUOp = 4'd5; #1;
    chk("rst_mfhi", E_MDUOut, 32'd0);
    E_MDUOp = 4'd0;
    reset = 1'b1;
    cyc();

    // Reset during RUN
    E_MDUOp = 4'd7; E_RD1 = 32'h12345678;
    cyc();
    E_MDUOp = 4'd0; E_RD1 = 32'd0;
    chk("mthi_hi", E_HI, 32'h12345678);
    E_MDUOp = 4'd1; E_RD1 = 32'd3; E_RD2 = 32'd4; E_Start = 1'b1;
    cyc();
    E_MDUOp = 4'd0; E_Start = 1'b0; E_RD1 = 32'd0; E_RD2 = 32'd0;
    chk("abort_busy1", {31'd0, E_Busy}, 32'd1);
    cyc(); cyc();
    reset = 1'b0; #1;
    chk("abort_busy", {31'd0, E_Busy}, 32'd0);
    chk("abort_hi", E_HI, 32'd0);
    chk("abort_lo", E_LO, 32'd0);
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) cyc();
    chk("abort_after_busy", {31'd0, E_Busy}, 32'd0);
    chk("abort_after_hi", E_HI, 32'd0);
    chk("abort_after_lo", E_LO, 32'd0);

    // mult -2 * 3
    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5);
    chk("mult_hi", E_HI, 32'hFFFFFFFF);
    chk("mult_lo", E_LO, 32'hFFFFFFFA);
    E_MDUOp = 4'd5; #1;
    chk("mult_mfhi", E_MDUOut, 32'hFFFFFFFF);
    E_MDUOp = 4'd6; #1;
    chk("mult_mflo", E_MDUOut, 32'hFFFFFFFA);
    E_MDUOp = 4'd9; #1;
    chk("op9_out", E_MDUOut, 32'd0);
    E_MDUOp = 4'd0;

    // multu same operands, back-to-back in the first idle cycle
    run_op("multu", 4'd2, 32'hFFFFFFFE, 32'd3, 5);
    chk("multu_hi", E_HI, 32'h00000002);
    chk("multu_lo", E_LO, 32'hFFFFFFFA);

    // Signed division
    run_op("div1", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
    chk("div1_lo", E_LO, 32'hFFFFFFFD);
    chk("div1_hi", E_HI, 32'hFFFFFFFF);
    run_op("div2", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
    chk("div2_lo", E_LO, 32'h80000000);
    chk("div2_hi", E_HI, 32'h00000000);

    // Unsigned division and divide by zero
    run_op("divu", 4'd4, 32'd7, 32'd2, 10);
    chk("divu_lo", E_LO, 32'd3);
    chk("divu_hi", E_HI, 32'd1);
    run_op("divz", 4'd4, 32'd5, 32'd0, 10);
    chk("divz_lo", E_LO, 32'd3);
    chk("divz_hi", E_HI, 32'd1);

    // Operations dropped while busy
    E_MDUOp = 4'd8; E_RD1 = 32'hAAAA5555;
    cyc();
    E_MDUOp = 4'd0; E_RD1 = 32'd0;
    chk("mtlo_lo", E_LO, 32'hAAAA5555);
    E_MDUOp = 4'd6; #1;
    chk("mtlo_mflo", E_MDUOut, 32'hAAAA5555);
    E_MDUOp = 4'd1; E_RD1 = 32'd2; E_RD2 = 32'd2; E_Start = 1'b1;
    cyc();
    E_MDUOp = 4'd0; E_Start = 1'b0; E_RD1 = 32'd0; E_RD2 = 32'd0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ign_busy%0d", i + 1), {31'd0, E_Busy}, 32'd1);
      if (i == 1) begin
        E_MDUOp = 4'd7; E_RD1 = 32'd1;
      end else if (i == 2) begin
        E_MDUOp = 4'd1; E_RD1 = 32'd5; E_RD2 = 32'd5; E_Start = 1'b1;
      end else begin
        E_MDUOp = 4'd0; E_RD1 = 32'd0; E_RD2 = 32'd0; E_Start = 1'b0;
      end
      cyc();
    end
    E_MDUOp = 4'd0; E_RD1 = 32'd0; E_RD2 = 32'd0; E_Start = 1'b0;
    chk("ign_busy_end", {31'd0, E_Busy}, 32'd0);
    chk("ign_hi", E_HI, 32'd0);
    chk("ign_lo", E_LO, 32'd4);
    cyc();
    chk("ign_no_relaunch", {31'd0, E_Busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit. It consumes the operands and control fields that the D/E pipeline register presents in E (`E_RD1`, `E_RD2`, MDU opcode, start strobe) and holds the architectural HI/LO registers. It runs multi-cycle `mult`/`multu`/`div`/`divu` in the background and exposes `E_Busy` so the hazard unit can stall MDU instructions sitting in D. It also serves `mfhi`/`mflo` reads and `mthi`/`mtlo` writes.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk`, input, 1: single system clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset; clears all state immediately while low.
- `E_RD1`, input, 32: operand A (rs value, forwarded). Source for `mthi`/`mtlo`.
- `E_RD2`, input, 32: operand B (rt value, forwarded).
- `E_MDUOp`, input, 4: operation code.
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu.
  - 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - 9–15 are treated as none.
- `E_Start`, input, 1: launch strobe. Meaningful only with ops 1–4; ignored otherwise.
- `E_Busy`, output, 1: high while a launched operation is in progress.
- `E_HI`, output, 32: current HI register.
- `E_LO`, output, 32: current LO register.
- `E_MDUOut`, output, 32: combinational read data.
  - HI when op = 5; LO when op = 6; 0 otherwise.

## Operation
- Registers:
  - HI, LO (32 each).
  - Pending-result registers PHI, PLO (32 each).
  - Down-counter `cnt` (4 bits, must hold `DIV_CYCLES`).
  - Pending-divzero flag.
- States: IDLE (`cnt` == 0) and RUN (`cnt` != 0). `E_Busy` = (`cnt` != 0).
- IDLE with `E_Start`=1 and op 1–4, at the clock edge:
  - Compute the result combinationally from `E_RD1`/`E_RD2` and capture it into PHI/PLO.
  - Load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`; the unit enters RUN.
- Op 1, mult: {PHI,PLO} = signed(A) × signed(B), full 64 bits.
- Op 2, multu: {PHI,PLO} = unsigned product, full 64 bits.
- Op 3, div: PLO = signed quotient, truncated toward zero; PHI = remainder, sign follows dividend.
  - 0x80000000 / 0xFFFFFFFF gives PLO = 0x80000000, PHI = 0.
- Op 4, divu: PLO = unsigned quotient, PHI = unsigned remainder.
- Divide by zero (B = 0, ops 3/4): the pending-divzero flag is set; on commit HI and LO keep their old values.
- RUN, at each clock edge:
  - `cnt` decrements.
  - On the 1→0 transition, HI <= PHI and LO <= PLO, unless divzero is pending.
- Op 7, mthi: HI <= `E_RD1` at the edge. Op 8, mtlo: LO <= `E_RD1` at the edge.
  - Both take effect only in IDLE.
- Ignored while RUN: `E_Start`, mthi and mtlo. They cause no state change and the running operation is unaffected.
  - The hazard unit guarantees these never occur in RUN. This rule is the defined fallback.
- mfhi/mflo read the HI/LO registers; there is no bypass of pending results.
- Hazard contract, implemented in the hazard unit:
  - Stall any MDU-class instruction (ops 1–8) in D while `E_Start` or `E_Busy` is high.
  - The stalled D instruction is released when `E_Busy` falls.

## Timing
- Reset (`reset` low, asynchronous): HI = 0, LO = 0, PHI = 0, PLO = 0, `cnt` = 0, divzero = 0.
  - Therefore `E_Busy` = 0 and `E_HI` = `E_LO` = 0.
  - `E_MDUOut` follows its combinational rule, which reads 0.
  - Reset mid-operation aborts it; there is no commit.
- Launch timing: start sampled at the edge ending cycle N.
  - `E_Busy` is high in cycles N+1 through N+L, where L = `MULT_CYCLES` or `DIV_CYCLES`.
  - New HI/LO are visible from cycle N+L+1.
  - `E_Busy` is low in cycle N itself; the start strobe covers that cycle for hazards.
- A back-to-back start is accepted in the first cycle that `E_Busy` is low (cycle N+L+1).
- mthi/mtlo in cycle N: the new value is visible on `E_HI`/`E_LO` and `E_MDUOut` from cycle N+1.
- Reset release takes effect on the next clock edge; no start is accepted in the same edge as reset deassertion.

## Test plan
- Reset during RUN:
  - Setup: mthi 0x12345678, then mult 3×4; pull `reset` low at the 3rd busy cycle.
  - Required: `E_Busy`, HI and LO are 0 immediately.
  - Required after release: HI/LO stay 0; no commit ever occurs.
- mult with negatives:
  - Stimulus: mult A = 0xFFFFFFFE (−2), B = 3, start at cycle 10.
  - Required: `E_Busy` high in cycles 11–15.
  - Required from cycle 16: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - Required: mfhi/mflo in cycle 16 return the same values.
- multu with the same operands:
  - Required: HI = 0x00000002, LO = 0xFFFFFFFA after 5 busy cycles.
- Signed division corner cases:
  - div −7 / 2: after 10 busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - div 0x80000000 / −1: LO = 0x80000000, HI = 0.
- Unsigned division and divide by zero:
  - divu 7 / 2: LO = 3, HI = 1.
  - Then divu 5 / 0: `E_Busy` high for 10 cycles; HI/LO stay 1 and 3 afterwards.
- Ignored operations during RUN:
  - Stimulus: mtlo 0xAAAA5555 in IDLE, then mult 2×2, then mthi 0x1 plus a second `E_Start` during busy.
  - Required: LO = 0xAAAA5555 after the mtlo.
  - Required: the busy window is unchanged at 5 cycles.
  - Required: final HI = 0, LO = 4.
